uart_tx_arbiter: RTL

Round-robin controller that shares the single UART transmit path between several packet sources. It grants one source at a time and copies that source's packet bytes into the 32-byte transmit FIFO inside `uart_tx`. It then raises `transmit_req_p`, holds it until `transmit_done_p`, and releases the link before arbitrating again. It sits between the telemetry/command producers and `uart_tx` in the top-level comms path.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// FIFO geometry and a one-hot to index helper.
package uart_pkg;

    localparam int FIFO_DEPTH_c = 32;
    localparam int BYTE_W_c     = 8;

    typedef enum logic [2:0] {
        ARB_IDLE_c      = 3'd0,
        ARB_LOAD_c      = 3'd1,
        ARB_REQ_c       = 3'd2,
        ARB_WAIT_DONE_c = 3'd3,
        ARB_RELEASE_c   = 3'd4
    } arb_state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first valid source after ptr
// (wrapping) wins, so the source at ptr itself is considered last.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [2:0]         ptr,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt
);

    localparam int IW = $clog2(NUM_SRC);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one packet source at a time, copies its bytes into the uart_tx
// FIFO, then runs the transmit_req/done handshake before re-arbitrating.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                    clk210_p,
    input  logic                    reset_n_p,
    input  logic [NUM_SRC-1:0]      src_valid_p,
    input  logic [8*NUM_SRC-1:0]    src_data_p,
    input  logic [NUM_SRC-1:0]      src_last_p,
    output logic [NUM_SRC-1:0]      src_ready_p,
    output logic [NUM_SRC-1:0]      src_ovf_p,
    input  logic                    ovf_clr_p,
    output logic [7:0]              fifo_tx_din_p,
    output logic                    fifo_tx_wr_en_p,
    input  logic                    fifo_tx_empty_p,
    input  logic [4:0]              fifo_tx_data_count_p,
    output logic                    transmit_req_p,
    input  logic                    transmit_done_p,
    output logic                    transmit_done_ack_p,
    output logic                    busy_p,
    output logic [2:0]              grant_idx_p
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    arb_state_t           state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           din_q, din_d;
    logic                 wr_en_q, wr_en_d;
    logic                 req_q, req_d;
    logic                 ack_q, ack_d;
    logic [NUM_SRC-1:0]   ovf_q, ovf_d;

    logic [NUM_SRC-1:0]   rr_gnt;
    logic [7:0]           rr_gnt_ext;
    logic [2:0]           rr_idx;
    logic [NUM_SRC-1:0]   grant_oh;
    logic                 sel_valid, sel_last;
    logic [7:0]           sel_data;
    logic                 fifo_idle;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .ptr (ptr_q),
        .req (src_valid_p),
        .gnt (rr_gnt)
    );

    always_comb begin
        rr_gnt_ext                = '0;
        rr_gnt_ext[NUM_SRC-1:0]   = rr_gnt;
    end
    assign rr_idx = onehot_to_idx(rr_gnt_ext);

    // Both views of the FIFO must agree it has drained before a new grant.
    assign fifo_idle = fifo_tx_empty_p && (fifo_tx_data_count_p == '0);

    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        grant_oh    = '0;
        src_ready_p = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid      = src_valid_p[i];
                sel_last       = src_last_p[i];
                sel_data       = src_data_p[8*i +: 8];
                grant_oh[i]    = 1'b1;
                src_ready_p[i] = (state_q == ARB_LOAD_c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        req_d   = req_q;
        ack_d   = 1'b0;
        ovf_d   = ovf_clr_p ? '0 : ovf_q;
        case (state_q)
            ARB_IDLE_c: begin
                req_d = 1'b0;
                if (fifo_idle && !transmit_done_p && (|rr_gnt)) begin
                    grant_d = rr_idx;
                    ptr_d   = rr_idx;
                    busy_d  = 1'b1;
                    state_d = ARB_LOAD_c;
                end
            end
            ARB_LOAD_c: begin
                if (sel_valid) begin
                    if (cnt_q < CNT_W'(MAX_LEN)) begin
                        wr_en_d = 1'b1;
                        din_d   = sel_data;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        // Applied after the clear so a simultaneous set wins.
                        ovf_d = ovf_d | grant_oh;
                    end
                    if (sel_last) state_d = ARB_REQ_c;
                end
            end
            ARB_REQ_c: begin
                req_d   = 1'b1;
                state_d = ARB_WAIT_DONE_c;
            end
            ARB_WAIT_DONE_c: begin
                if (transmit_done_p) begin
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ARB_RELEASE_c;
                end
            end
            ARB_RELEASE_c: begin
                if (!transmit_done_p) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ARB_IDLE_c;
                end
            end
            default: begin
                state_d = ARB_IDLE_c;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                din_d   = '0;
                req_d   = 1'b0;
                ovf_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q <= ARB_IDLE_c;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_tx_din_p       = din_q;
    assign fifo_tx_wr_en_p     = wr_en_q;
    assign transmit_req_p      = req_q;
    assign transmit_done_ack_p = ack_q;
    assign busy_p              = busy_q;
    assign grant_idx_p         = grant_q;
    assign src_ovf_p           = ovf_q;

endmodule
